// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: round-robin sharing of the register file's single write port
// among N requesters, with a registered output stage and write/drop counters.
module rf_wb_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [5*N-1:0]  req_addr,
  input  logic [32*N-1:0] req_data,
  output logic [N-1:0]    req_ready,
  input  logic            hold,
  output logic [4:0]      rf_addr,
  output logic [31:0]     rf_wd,
  output logic            rf_wr,
  output logic [31:0]     wb_cnt,
  output logic [15:0]     drop_cnt
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] ptr;
  logic [PtrW-1:0] ptr_nxt;
  logic [PtrW-1:0] idx;
  logic            accept;
  logic [4:0]      sel_addr;
  logic [31:0]     sel_data;

  logic [4:0]  addr_arr [N];
  logic [31:0] data_arr [N];

  for (genvar g = 0; g < N; g++) begin : gen_unpack
    assign addr_arr[g] = req_addr[5*g +: 5];
    assign data_arr[g] = req_data[32*g +: 32];
  end

  // Scan from ptr upwards (mod N); the first valid requester wins.
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    ptr_nxt   = ptr;
    idx       = '0;
    if (!hold) begin
      for (int unsigned k = 0; k < N; k++) begin
        idx = PtrW'((32'(ptr) + k) % N);
        if (!accept && req_valid[idx]) begin
          accept         = 1'b1;
          req_ready[idx] = 1'b1;
          sel_addr       = addr_arr[idx];
          sel_data       = data_arr[idx];
          ptr_nxt        = (idx == PtrW'(N - 1)) ? '0 : idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      rf_addr  <= '0;
      rf_wd    <= '0;
      rf_wr    <= 1'b0;
      wb_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      ptr   <= ptr_nxt;
      // Writes to $0 are accepted but never enable the register file.
      rf_wr <= accept && (sel_addr != 5'd0);
      if (accept) begin
        rf_addr <= sel_addr;
        rf_wd   <= sel_data;
      end
      if (accept && (sel_addr == 5'd0) && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      if (rf_wr) begin
        wb_cnt <= wb_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: each cycle pushes the expected output-stage contents,
// which are popped and compared one cycle later.
module tb_rf_wb_arbiter;

  localparam int unsigned N = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [5*N-1:0]  req_addr = '0;
  logic [32*N-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            hold = 1'b0;
  logic [4:0]      rf_addr;
  logic [31:0]     rf_wd;
  logic            rf_wr;
  logic [31:0]     wb_cnt;
  logic [15:0]     drop_cnt;

  rf_wb_arbiter #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_ready(req_ready),
    .hold     (hold),
    .rf_addr  (rf_addr),
    .rf_wd    (rf_wd),
    .rf_wr    (rf_wr),
    .wb_cnt   (wb_cnt),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        wr;
  } wb_t;

  wb_t         exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  logic [31:0] exp_wb;
  logic [15:0] exp_drop;
  logic [4:0]  last_addr;
  logic [31:0] last_data;
  logic [31:0] rf_mem [32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr[5*i +: 5]  = a;
    req_data[32*i +: 32] = d;
  endtask

  // One clock cycle: drive, check at negedge, push expectation for the next cycle.
  task automatic cycle(input logic [N-1:0] v, input logic h, input logic [N-1:0] exp_rdy);
    wb_t e;
    wb_t n;
    int  g;
    req_valid = v;
    hold      = h;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL sb_empty: got empty queue, expected an entry");
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    check("rf_wr", rf_wr, e.wr);
    check("rf_addr", rf_addr, e.addr);
    check("rf_wd", rf_wd, e.data);
    check("wb_cnt", wb_cnt, exp_wb);
    check("drop_cnt", drop_cnt, exp_drop);
    check("req_ready", req_ready, exp_rdy);
    if (rf_wr === 1'b1) rf_mem[rf_addr] = rf_wd;
    if (e.wr) exp_wb++;
    g = -1;
    for (int i = 0; i < N; i++) if (exp_rdy[i]) g = i;
    if (g >= 0) begin
      last_addr = req_addr[5*g +: 5];
      last_data = req_data[32*g +: 32];
      n.wr      = (last_addr != 5'd0);
      if (last_addr == 5'd0 && exp_drop != 16'hFFFF) exp_drop++;
    end else begin
      n.wr = 1'b0;
    end
    n.addr = last_addr;
    n.data = last_data;
    exp_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_rf_wr", rf_wr, 1'b0);
    check("rst_rf_addr", rf_addr, 5'd0);
    check("rst_wb_cnt", wb_cnt, 32'd0);
    check("rst_drop_cnt", drop_cnt, 16'd0);
    req_valid = '0;
    hold      = 1'b0;
    exp_q.delete();
    exp_wb    = '0;
    exp_drop  = '0;
    last_addr = '0;
    last_data = '0;
    exp_q.push_back('0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    cycle(3'b000, 1'b0, 3'b000);
    cycle(3'b000, 1'b0, 3'b000);

    // Single requester, then confirm ptr moved to 2.
    set_req(0, 5'd1, 32'h11);
    set_req(1, 5'd5, 32'hDEADBEEF);
    set_req(2, 5'd3, 32'h33);
    cycle(3'b010, 1'b0, 3'b010);
    cycle(3'b000, 1'b0, 3'b000);
    cycle(3'b111, 1'b0, 3'b100);
    cycle(3'b000, 1'b0, 3'b000);
    cycle(3'b000, 1'b0, 3'b000);

    // Reset in the middle of a write.
    cycle(3'b001, 1'b0, 3'b001);
    check("pre_rst_wr", rf_wr, 1'b1);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(3'b000, 1'b0, 3'b000);

    // Round-robin with all requesters valid.
    set_req(0, 5'd1, 32'h100);
    set_req(1, 5'd2, 32'h200);
    set_req(2, 5'd3, 32'h300);
    for (int i = 0; i < 6; i++) cycle(3'b111, 1'b0, 3'(1 << (i % 3)));
    cycle(3'b000, 1'b0, 3'b000);
    cycle(3'b000, 1'b0, 3'b000);
    check("rr_wb_cnt", wb_cnt, 32'd6);

    // Write to $0 is dropped.
    set_req(0, 5'd0, 32'h1234);
    cycle(3'b001, 1'b0, 3'b001);
    cycle(3'b000, 1'b0, 3'b000);
    check("drop_cnt_after", drop_cnt, 16'd1);
    check("wb_after_drop", wb_cnt, 32'd6);

    // Hold for three cycles, then resume from the saved pointer.
    set_req(0, 5'd4, 32'h400);
    cycle(3'b111, 1'b0, 3'b010);
    for (int i = 0; i < 3; i++) cycle(3'b111, 1'b1, 3'b000);
    cycle(3'b111, 1'b0, 3'b100);
    cycle(3'b000, 1'b0, 3'b000);
    cycle(3'b000, 1'b0, 3'b000);

    // Same-address conflict with ptr=1: A then B, B survives.
    set_req(0, 5'd9, 32'h999);
    cycle(3'b001, 1'b0, 3'b001);
    set_req(1, 5'd7, 32'hA);
    set_req(2, 5'd7, 32'hB);
    cycle(3'b110, 1'b0, 3'b010);
    cycle(3'b100, 1'b0, 3'b100);
    cycle(3'b000, 1'b0, 3'b000);
    cycle(3'b000, 1'b0, 3'b000);
    check("rf_r7", rf_mem[7], 32'hB);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter for the CPU's single-write-port register file. It shares the register file write port (write address, write data, write enable) among N write-back requesters, such as the ALU pipe, load unit and mul/div unit. It uses valid/ready handshakes, round-robin fairness and a registered output stage. It sits between the execution units and the register file, and drives the register file's write port directly.

## Interface
- N, 3, number of requesters; legal range 2..4.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low.
- req_valid  input  N  per-requester write request; bit i belongs to requester i.
- req_addr  input  5*N  destination register; requester i uses bits [5i+4:5i].
- req_data  input  32*N  write data; requester i uses bits [32i+31:32i].
- req_ready  output  N  one-hot grant; the request is accepted when req_valid[i] && req_ready[i].
- hold  input  1  blocks all new grants (exception or stall); the output stage still retires.
- rf_addr  output  5  register file write address.
- rf_wd  output  32  register file write data.
- rf_wr  output  1  register file write enable.
- wb_cnt  output  32  count of cycles with rf_wr=1.
- drop_cnt  output  16  count of accepted writes that targeted $0.

## Operation
- State:
  - round-robin pointer ptr, log2(N) bits, range 0..N-1.
  - output stage: rf_addr, rf_wd, rf_wr.
  - counters wb_cnt and drop_cnt.
- Grant selection is combinational from req_valid, ptr and hold:
  - hold=1 → req_ready = 0.
  - Otherwise scan i = ptr, ptr+1, … (mod N) and grant the first requester with req_valid[i]=1.
  - At most one req_ready bit is ever set.
  - req_ready[i]=1 only when req_valid[i]=1.
- Every grant is an accept. The arbiter has no back-pressure from the register file.
- Pointer update: after accepting requester g, ptr ← (g+1) mod N. With no accept, ptr holds.
- Output stage on an accept from requester g:
  - rf_addr ← req_addr[g] and rf_wd ← req_data[g].
  - rf_wr ← 1 if req_addr[g] ≠ 0, else 0.
  - A $0 target also increments drop_cnt.
- Output stage with no accept: rf_wr ← 0, and rf_addr/rf_wd hold their last values.
- wb_cnt increments on every rising edge where rf_wr=1. It wraps at 2^32.
- drop_cnt saturates at 16'hFFFF.
- Requesters must hold valid, addr and data stable until accepted. The arbiter does not check this.
- Two requesters targeting the same register in the same cycle are serialised in round-robin order. The later one wins in the register file. Program-order resolution is the issue logic's job, not this block's.
- Fairness: a requester that holds valid continuously is granted within N cycles of hold being low.

## Timing
- Reset (rst=0, asynchronous): ptr=0, rf_addr=0, rf_wd=0, rf_wr=0, wb_cnt=0, drop_cnt=0.
- req_ready is combinational and valid in the same cycle as req_valid.
- Reset mid-operation: any write held in the output stage is discarded and rf_wr drops immediately. No write reaches the register file.
- Latency: accept at edge T → rf_wr=1 with the accepted addr/data during cycle T+1. The register file commits at edge T+1.
- Throughput: one write per cycle, sustained.
- hold asserted in cycle T:
  - No accept at edge T.
  - A write already in the output stage still appears in cycle T (it was accepted at T-1).
  - rf_wr=0 in cycle T+1.
- Deassertion of rst is synchronous to clk from the consumer's view. The first accept is possible at the first rising edge with rst=1.
- Register file bypass (rd = write data when the read address matches the write address and the write is enabled) operates on rf_addr/rf_wd/rf_wr. Those signals are registered, so the bypass path starts at a flop.

## Test plan
- **Reset and idle:** rst=0 mid-write with rf_wr=1 → rf_wr=0 immediately. After release with req_valid=0 → rf_wr stays 0 and wb_cnt=0.
- **Single requester:** req_valid=3'b010, addr=5, data=32'hDEADBEEF → req_ready=3'b010 in the same cycle. Next cycle rf_wr=1, rf_addr=5, rf_wd=32'hDEADBEEF. ptr becomes 2.
- **Round-robin:** all three valid for 6 cycles after reset → grants in order 0,1,2,0,1,2. wb_cnt=6 after the output stage drains.
- **$0 drop:** requester 0 writes addr=0, data=32'h1234 → req_ready[0]=1, rf_wr=0 next cycle, drop_cnt=1, wb_cnt unchanged.
- **Hold:** all valid, hold=1 for 3 cycles → req_ready=0 and ptr unchanged. rf_wr=1 only in the first hold cycle (from the prior accept), then 0. Releasing hold resumes from the saved ptr.
- **Same-address conflict:** requesters 1 and 2 both target r7 (data 32'hA and 32'hB) with ptr=1 → writes A then B on consecutive cycles. A register file read of r7 afterwards returns 32'hB.
